// File: rtl/acc_sequencer.sv
// Accumulator controller that sequences LOAD/ADD/SUB/CLR commands through an external
// 16-bit combinational adder. SUB takes two adder passes because the adder has no carry-in.
module acc_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_data,
  output logic [WIDTH-1:0] o_alu_x,
  output logic [WIDTH-1:0] o_alu_y,
  input  logic [WIDTH-1:0] i_alu_z,
  input  logic             i_alu_sign,
  input  logic             i_alu_zero,
  input  logic             i_alu_carry,
  input  logic             i_alu_parity,
  output logic [WIDTH-1:0] o_acc,
  output logic [4:0]       o_flags,
  output logic             o_done
);

  localparam logic [1:0] OpLoad = 2'b00;
  localparam logic [1:0] OpAdd  = 2'b01;
  localparam logic [1:0] OpSub  = 2'b10;
  localparam logic [1:0] OpClr  = 2'b11;

  localparam logic [4:0]       FlagsRst = 5'b01010;
  localparam logic [WIDTH-1:0] One      = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StIdle,
    StNeg,
    StExec
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [4:0]       r_flags;
  logic [WIDTH-1:0] r_alu_x;
  logic [WIDTH-1:0] r_alu_y;
  logic             r_done;
  logic             r_opd_msb;
  logic             r_is_sub;
  logic             r_c1;

  logic w_accept;
  logic w_acc_msb;
  logic w_z_msb;
  logic w_carry;
  logic w_ovf;

  // {sign, zero, carry, parity, overflow} for a value written directly (LOAD/CLR)
  function automatic logic [4:0] value_flags(input logic [WIDTH-1:0] v);
    return {v[WIDTH-1], (v == '0), 1'b0, ~^v, 1'b0};
  endfunction

  assign o_cmd_ready = (r_state == StIdle) & ~i_rst;
  assign w_accept    = i_cmd_valid & o_cmd_ready;

  assign w_acc_msb = r_acc[WIDTH-1];
  assign w_z_msb   = i_alu_z[WIDTH-1];

  // For SUB, carry means "no borrow": either pass may produce the carry-out.
  assign w_carry = r_is_sub ? (r_c1 | i_alu_carry) : i_alu_carry;
  assign w_ovf   = r_is_sub ? ((w_acc_msb ^ r_opd_msb) & (w_z_msb ^ w_acc_msb))
                            : ((w_acc_msb & r_opd_msb & ~w_z_msb) |
                               (~w_acc_msb & ~r_opd_msb & w_z_msb));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_acc     <= '0;
      r_flags   <= FlagsRst;
      r_alu_x   <= '0;
      r_alu_y   <= '0;
      r_done    <= 1'b0;
      r_opd_msb <= 1'b0;
      r_is_sub  <= 1'b0;
      r_c1      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_opd_msb <= i_cmd_data[WIDTH-1];
            unique case (i_cmd_op)
              OpLoad: begin
                r_acc   <= i_cmd_data;
                r_flags <= value_flags(i_cmd_data);
                r_done  <= 1'b1;
              end
              OpClr: begin
                r_acc   <= '0;
                r_flags <= value_flags('0);
                r_done  <= 1'b1;
              end
              OpAdd: begin
                r_alu_x  <= r_acc;
                r_alu_y  <= i_cmd_data;
                r_is_sub <= 1'b0;
                r_state  <= StExec;
              end
              OpSub: begin
                // First pass forms the two's complement of the operand.
                r_alu_x  <= ~i_cmd_data;
                r_alu_y  <= One;
                r_is_sub <= 1'b1;
                r_state  <= StNeg;
              end
              default: r_state <= StIdle;
            endcase
          end
        end
        StNeg: begin
          r_c1    <= i_alu_carry;
          r_alu_x <= r_acc;
          r_alu_y <= i_alu_z;
          r_state <= StExec;
        end
        StExec: begin
          r_acc   <= i_alu_z;
          r_flags <= {i_alu_sign, i_alu_zero, w_carry, i_alu_parity, w_ovf};
          r_done  <= 1'b1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_alu_x = r_alu_x;
  assign o_alu_y = r_alu_y;
  assign o_acc   = r_acc;
  assign o_flags = r_flags;
  assign o_done  = r_done;

endmodule

// File: tb/tb_acc_sequencer.sv
// Bench for acc_sequencer: models the external adder, drives directed and random commands,
// and checks each done pulse against an arithmetic reference model via a scoreboard.
module tb_acc_sequencer;

  localparam logic [1:0] OpLoad = 2'b00;
  localparam logic [1:0] OpAdd  = 2'b01;
  localparam logic [1:0] OpSub  = 2'b10;
  localparam logic [1:0] OpClr  = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [15:0] alu_x, alu_y, alu_z;
  logic        alu_sign, alu_zero, alu_carry, alu_parity;
  logic [15:0] acc;
  logic [4:0]  flags;
  logic        done;
  logic [16:0] sum;

  always #5 clk = ~clk;

  // Combinational adder/flag stage the block drives.
  assign sum        = {1'b0, alu_x} + {1'b0, alu_y};
  assign alu_z      = sum[15:0];
  assign alu_carry  = sum[16];
  assign alu_sign   = alu_z[15];
  assign alu_zero   = (alu_z == 16'h0000);
  assign alu_parity = ~^alu_z;

  acc_sequencer #(.WIDTH(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_op    (cmd_op),
    .i_cmd_data  (cmd_data),
    .o_alu_x     (alu_x),
    .o_alu_y     (alu_y),
    .i_alu_z     (alu_z),
    .i_alu_sign  (alu_sign),
    .i_alu_zero  (alu_zero),
    .i_alu_carry (alu_carry),
    .i_alu_parity(alu_parity),
    .o_acc       (acc),
    .o_flags     (flags),
    .o_done      (done)
  );

  typedef struct {
    logic [15:0] acc;
    logic [4:0]  flags;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [15:0] m_acc    = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model: plain arithmetic on integers, not adder passes.
  task automatic model(input logic [1:0] op, input logic [15:0] d,
                       output logic [15:0] na, output logic [4:0] f);
    int   sa, sd, r;
    logic c, v;
    sa = int'($signed(m_acc));
    sd = int'($signed(d));
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      OpLoad: na = d;
      OpClr:  na = 16'h0000;
      OpAdd: begin
        na = m_acc + d;
        c  = (int'(m_acc) + int'(d)) > 65535;
        r  = sa + sd;
        v  = (r > 32767) || (r < -32768);
      end
      default: begin
        na = m_acc - d;
        c  = (m_acc >= d);
        r  = sa - sd;
        v  = (r > 32767) || (r < -32768);
      end
    endcase
    f = {na[15], na == 16'h0000, c, ~^na, v};
  endtask

  // Scoreboard monitor: each done pulse pops one expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: done=1 with no command outstanding (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_acc", 32'(acc), 32'(e.acc));
        check("sb_flags", 32'(flags), 32'(e.flags));
        check("sb_done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Returns #1 after the accept edge, i.e. in cycle k+1.
  task automatic issue(input logic [1:0] op, input logic [15:0] d);
    int          n;
    exp_t        e;
    logic [15:0] na;
    logic [4:0]  f;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: cmd_ready stayed 0, expected 1 within 20 cycles");
    end else begin
      model(op, d, na, f);
      m_acc   = na;
      e.acc   = na;
      e.flags = f;
      e.cyc   = cyc + ((op == OpAdd) ? 2 : (op == OpSub) ? 3 : 1);
      sb.push_back(e);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic [1:0]  op;
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = OpLoad;
    cmd_data  = 16'hFFFF;

    repeat (2) begin
      @(negedge clk);
      check("rst_ready", 32'(cmd_ready), 32'd0);
      check("rst_acc", 32'(acc), 32'h0000);
      check("rst_flags", 32'(flags), 32'b01010);
      check("rst_done", 32'(done), 32'd0);
    end
    rst       = 1'b0;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1 check("ready_after_rst", 32'(cmd_ready), 32'd1);

    issue(OpLoad, 16'h7FFF);
    issue(OpAdd, 16'h0001);
    check("add_ready_low", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1 check("add_ready_back", 32'(cmd_ready), 32'd1);
    wait_idle();
    check("d1_acc", 32'(acc), 32'h8000);
    check("d1_flags", 32'(flags), 32'b10001);

    issue(OpLoad, 16'hFFFF);
    issue(OpAdd, 16'h0001);
    wait_idle();
    check("d2_acc", 32'(acc), 32'h0000);
    check("d2_flags", 32'(flags), 32'b01110);

    issue(OpLoad, 16'h0005);
    issue(OpSub, 16'h0007);
    wait_idle();
    check("d3_acc", 32'(acc), 32'hFFFE);
    check("d3_flags", 32'(flags), 32'b10000);

    issue(OpLoad, 16'h1234);
    issue(OpSub, 16'h0000);
    wait_idle();
    check("d4_acc", 32'(acc), 32'h1234);
    check("d4_flags", 32'(flags), 32'b00100);

    issue(OpClr, 16'h5555);
    issue(OpSub, 16'h8000);
    wait_idle();
    check("d5_acc", 32'(acc), 32'h8000);
    check("d5_flags", 32'(flags), 32'b10001);

    // LOAD pulsed during NEG must be ignored.
    issue(OpSub, 16'h0100);
    cmd_valid = 1'b1;
    cmd_op    = OpLoad;
    cmd_data  = 16'hAAAA;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    check("ignored_load_acc", 32'(acc), 32'(m_acc));

    // Reset during NEG aborts the SUB with no done pulse.
    issue(OpSub, 16'h0001);
    rst = 1'b1;
    sb.delete(sb.size() - 1);
    m_acc = 16'h0000;
    @(posedge clk);
    #1;
    check("abort_done", 32'(done), 32'd0);
    check("abort_acc", 32'(acc), 32'h0000);
    check("abort_flags", 32'(flags), 32'b01010);
    check("abort_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_ready_back", 32'(cmd_ready), 32'd1);
    check("abort_acc_hold", 32'(acc), 32'h0000);

    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       d = 16'h0000;
        1:       d = 16'hFFFF;
        2:       d = 16'h8000;
        3:       d = 16'h7FFF;
        default: d = 16'($urandom);
      endcase
      issue(op, d);
    end
    wait_idle();
    check("final_acc", 32'(acc), 32'(m_acc));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
